// File: rtl/loa_pipe_adder_if.sv
// Valid/ready bus for loa_pipe_adder: operand beat in, sum out.
// master drives operands and out_ready; slave is the adder.
interface loa_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;

    modport master (
        output in_valid, in_a, in_b, approx_en, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, approx_en, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/loa_pipe_adder.sv
// Pipelined WIDTH-bit unsigned adder with an optional Lower-part OR Adder
// mode on the low APPROX_BITS bits, selected per beat by approx_en.
// The carry chain is cut into STAGES equal segments, one register stage each.
//
// Build option: LOA_CARRY_EN
//   defined   -> in approx mode the carry out of bit APPROX_BITS-1 is
//                a & b of that bit (LOA carry prediction)
//   undefined -> that carry is 0 (plain OR truncation)
//
// The whole pipeline advances together: en = !out_valid | out_ready.
// With en low every stage holds, so out_sum/out_valid stay stable under stall.
module loa_pipe_adder #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 4,
    parameter int STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    loa_pipe_adder_if.slave      bus
);
    localparam int SEG = WIDTH / STAGES;

    logic en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Registered state leaving this stage
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        // What this stage sees from upstream
        logic             src_v;
        logic             src_c;
        logic             src_apx;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;

        logic [WIDTH-1:0] nxt_s;
        logic             nxt_c;
        logic             carry;

        if (k == 0) begin : g_src_in
            assign src_v   = bus.in_valid;
            assign src_c   = 1'b0;
            assign src_apx = bus.approx_en;
            assign src_a   = bus.in_a;
            assign src_b   = bus.in_b;
            assign src_s   = '0;
        end else begin : g_src_prev
            assign src_v   = g_stage[k-1].v_q;
            assign src_c   = g_stage[k-1].c_q;
            assign src_apx = g_stage[k-1].g_fwd.apx_q;
            assign src_a   = g_stage[k-1].g_fwd.a_q;
            assign src_b   = g_stage[k-1].g_fwd.b_q;
            assign src_s   = g_stage[k-1].s_q;
        end

        // Ripple through this stage's segment; LOA bits OR and kill the carry
        always_comb begin
            nxt_s = src_s;
            carry = src_c;
            for (int j = 0; j < SEG; j++) begin
                if (src_apx && ((k * SEG + j) < APPROX_BITS)) begin
                    nxt_s[k*SEG+j] = src_a[k*SEG+j] | src_b[k*SEG+j];
                    if ((k * SEG + j) == (APPROX_BITS - 1)) begin
`ifdef LOA_CARRY_EN
                        carry = src_a[k*SEG+j] & src_b[k*SEG+j];
`else
                        carry = 1'b0;
`endif
                    end else begin
                        carry = 1'b0;
                    end
                end else begin
                    nxt_s[k*SEG+j] = src_a[k*SEG+j] ^ src_b[k*SEG+j] ^ carry;
                    carry = (src_a[k*SEG+j] & src_b[k*SEG+j]) |
                            (src_a[k*SEG+j] & carry) |
                            (src_b[k*SEG+j] & carry);
                end
            end
            nxt_c = carry;
        end

        // Valid, carry and partial sum advance together with the pipeline
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= src_v;
                c_q <= nxt_c;
                s_q <= nxt_s;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic             apx_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Operands and mode ride along to the stages that still need them
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    apx_q <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else if (en) begin
                    apx_q <= src_apx;
                    a_q   <= src_a;
                    b_q   <= src_b;
                end
            end
        end else begin : g_last
            // Bits of the operands below the last segment are already consumed
            logic unused_src;
            assign unused_src = ^{src_a, src_b};
        end
    end

    assign en            = !g_stage[STAGES-1].v_q | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.out_sum   = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].s_q};

endmodule

// File: tb/tb_loa_pipe_adder.sv
// Self-checking bench for loa_pipe_adder (WIDTH=16, APPROX_BITS=4, STAGES=2).
// Reference model works on whole integers: exact = a+b; approx = OR of the
// low part, integer add of the high parts plus the predicted carry.
module tb_loa_pipe_adder;
    localparam int WIDTH       = 16;
    localparam int APPROX_BITS = 4;
    localparam int STAGES      = 2;

    typedef logic [WIDTH:0]   sum_t;
    typedef logic [WIDTH-1:0] op_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    loa_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    loa_pipe_adder #(
        .WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS), .STAGES(STAGES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic sum_t model(input op_t a, input op_t b, input logic apx);
        longint unsigned ua, ub, lo, hi, cp, mask;
        ua = 64'(a);
        ub = 64'(b);
        if (!apx || APPROX_BITS == 0)
            return sum_t'(ua + ub);
        mask = (64'd1 << APPROX_BITS) - 64'd1;
        lo   = (ua | ub) & mask;
`ifdef LOA_CARRY_EN
        cp = (ua >> (APPROX_BITS - 1)) & (ub >> (APPROX_BITS - 1)) & 64'd1;
`else
        cp = 64'd0;
`endif
        hi = (ua >> APPROX_BITS) + (ub >> APPROX_BITS) + cp;
        return sum_t'((hi << APPROX_BITS) | lo);
    endfunction

    // Driver: one beat into an idle pipe, reports the result and edge count
    task automatic send_one(input op_t a, input op_t b, input logic apx,
                            output sum_t s, output int lat, output logic acc);
        @(posedge clk); #1;
        bus.in_a = a; bus.in_b = b; bus.approx_en = apx;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        s   = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = 99;
        s = bus.out_sum;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_sum !== sum_t'(0)) begin
            n_fail++; $display("FAIL reset_out_sum got %h want 0", bus.out_sum);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        op_t  da [5] = '{16'h00FF, 16'h0009, 16'h0009, 16'hFFFF, 16'hFFFF};
        op_t  db [5] = '{16'h0001, 16'h0008, 16'h0008, 16'h0001, 16'h0001};
        logic dx [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        sum_t want [5];
        sum_t s;
        int   lat;
        logic acc;
        want[0] = 17'h00100;
`ifdef LOA_CARRY_EN
        want[1] = 17'h00019;
`else
        want[1] = 17'h00009;
`endif
        want[2] = 17'h00011;
        want[3] = 17'h10000;
        want[4] = 17'h0FFFF;
        for (int i = 0; i < 5; i++) begin
            send_one(da[i], db[i], dx[i], s, lat, acc);
            n_checks++;
            if (s !== want[i] || acc !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_%0d sum got %h want %h (accepted=%b)", i, s, want[i], acc);
            end
            n_checks++;
            if (lat !== STAGES) begin
                n_fail++; $display("FAIL latency_%0d got %0d want %0d", i, lat, STAGES);
            end
        end
    endtask

    task automatic test_backpressure();
        op_t  ba [4];
        op_t  bb [4];
        logic bx [4];
        int   sent = 0;
        int   got  = 0;
        sum_t held;
        for (int i = 0; i < 4; i++) begin
            ba[i] = op_t'($urandom); bb[i] = op_t'($urandom); bx[i] = 1'($urandom_range(1));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (sent < 4);
            bus.in_a = ba[sent % 4]; bus.in_b = bb[sent % 4]; bus.approx_en = bx[sent % 4];
            @(negedge clk);
            if (c >= 3) begin
                n_checks++;
                if (bus.out_sum !== held) begin
                    n_fail++; $display("FAIL bp_hold got %h want %h", bus.out_sum, held);
                end
            end
            held = bus.out_sum;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (sent !== STAGES) begin
            n_fail++; $display("FAIL bp_accepted got %0d want %0d", sent, STAGES);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_stall in_ready %b out_valid %b want 0/1", bus.in_ready, bus.out_valid);
        end
        n_checks++;
        if (bus.out_sum !== model(ba[0], bb[0], bx[0])) begin
            n_fail++; $display("FAIL bp_head got %h want %h", bus.out_sum, model(ba[0], bb[0], bx[0]));
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30 && got < 4; c++) begin
            bus.in_valid = (sent < 4);
            bus.in_a = ba[sent % 4]; bus.in_b = bb[sent % 4]; bus.approx_en = bx[sent % 4];
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (bus.out_sum !== model(ba[got], bb[got], bx[got])) begin
                    n_fail++;
                    $display("FAIL bp_drain_%0d got %h want %h", got, bus.out_sum, model(ba[got], bb[got], bx[got]));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (got !== 4) begin
            n_fail++; $display("FAIL bp_drain_count got %0d want 4", got);
        end
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   got  = 0;
        sum_t want;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 8; c++) begin
            bus.in_valid = (sent < 8);
            bus.in_a = 16'h000F; bus.in_b = 16'h0001; bus.approx_en = sent[0];
            @(negedge clk);
            if (bus.out_valid) begin
                want = got[0] ? 17'h0000F : 17'h00010;
                n_checks++;
                if (bus.out_sum !== want) begin
                    n_fail++; $display("FAIL b2b_%0d got %h want %h", got, bus.out_sum, want);
                end
                got++;
            end else if (got > 0 && got < 8) begin
                n_checks++;
                n_fail++; $display("FAIL b2b_bubble after %0d results got out_valid 0 want 1", got);
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (got !== 8) begin
            n_fail++; $display("FAIL b2b_count got %0d want 8", got);
        end
    endtask

    task automatic test_random_stream(input int n, input int ready_pct);
        sum_t exp_q [$];
        sum_t held;
        sum_t want;
        logic hold_chk = 1'b0;
        logic pend = 1'b0;
        int   sent = 0;
        int   got  = 0;
        for (int c = 0; c < 5000 && got < n; c++) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(99) < ready_pct);
            if (!pend) begin
                if (sent < n && $urandom_range(3) != 0) begin
                    bus.in_a = op_t'($urandom); bus.in_b = op_t'($urandom);
                    bus.approx_en = 1'($urandom_range(1));
                    bus.in_valid = 1'b1;
                    pend = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (hold_chk) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_sum !== held) begin
                    n_fail++;
                    $display("FAIL rnd_stall_hold got %b/%h want 1/%h", bus.out_valid, bus.out_sum, held);
                end
            end
            hold_chk = bus.out_valid && !bus.out_ready;
            held = bus.out_sum;
            if (bus.out_valid && bus.out_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (bus.out_sum !== want) begin
                    n_fail++; $display("FAIL rnd_result_%0d got %h want %h", got, bus.out_sum, want);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.approx_en));
                sent++;
                pend = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (got !== n) begin
            n_fail++; $display("FAIL rnd_count got %0d want %0d", got, n);
        end
    endtask

    task automatic test_reset_mid();
        sum_t s;
        int   lat;
        logic acc;
        int   seen = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = 16'h1234; bus.in_b = 16'h4321; bus.approx_en = 1'b0;
        @(posedge clk); #1;
        bus.in_a = 16'h0F0F;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== sum_t'(0)) begin
            n_fail++;
            $display("FAIL midreset_clear got %b/%h want 0/0", bus.out_valid, bus.out_sum);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL midreset_stale got %0d results want 0", seen);
        end
        send_one(16'h00A5, 16'h005A, 1'b0, s, lat, acc);
        n_checks++;
        if (s !== 17'h000FF || lat !== STAGES) begin
            n_fail++; $display("FAIL midreset_recover got %h lat %0d want 000ff lat %0d", s, lat, STAGES);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random_stream(200, 100);
        test_random_stream(200, 40);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
